// File: rtl/mux_nto1_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_pkg
// Purpose  : Shared types and helpers for the N:1 scanning multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
package mux_pkg;

  // Operating mode; doubles as the state encoding of the top level.
  typedef enum logic [0:0] {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Select width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_nto1_scan_ch_next_enabled.sv
`default_nettype none
// ============================================================================
// Module   : ch_next_enabled
// Purpose  : Rotating-priority search for the next enabled channel strictly
//            above cur (modulo N_CH); cur itself is the last candidate.
// Revision : 1.0 - initial release
// ============================================================================
module ch_next_enabled #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input  logic [N_CH-1:0]  ch_en,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             found,
  output logic             wraps
);

  logic [SEL_W-1:0] w_idx;

  // Walk candidates farthest-first so the nearest enabled index wins last.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    wraps = 1'b0;
    w_idx = '0;
    for (int i = N_CH; i >= 1; i--) begin
      w_idx = SEL_W'((int'(cur) + i) % N_CH);
      if (ch_en[w_idx]) begin
        nxt   = w_idx;
        found = 1'b1;
        wraps = (w_idx <= cur);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_nto1_scan.sv
`default_nettype none
// ============================================================================
// Module   : mux_nto1_scan
// Purpose  : Registered N-channel multiplexer with enable mask, direct select
//            and an auto-scan mode with programmable dwell; every output word
//            is tagged with its source channel.
// Revision : 1.0 - initial release
// ============================================================================
module mux_nto1_scan
  import mux_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 8,
  parameter int DWELL_W = 8,
  localparam int SEL_W  = clog2_min1(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] din,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [WIDTH-1:0]      y,
  output logic [SEL_W-1:0]      y_ch,
  output logic                  y_valid,
  output logic                  wrap
);

  localparam logic [SEL_W-1:0] c_last = SEL_W'(N_CH - 1);
  localparam logic [SEL_W:0]   c_n_ch = (SEL_W + 1)'(N_CH);

  mode_e               r_state;
  mode_e               w_state_nxt;
  mode_e               w_mode;

  logic [SEL_W-1:0]    r_cur;
  logic [DWELL_W-1:0]  r_cnt;
  logic [DWELL_W-1:0]  r_dwell_l;
  logic                r_pend;
  logic [WIDTH-1:0]    r_y;
  logic [SEL_W-1:0]    r_y_ch;
  logic                r_valid;
  logic                r_wrap;

  logic [WIDTH-1:0]    w_ch [N_CH];
  logic                w_sel_ok;
  logic [SEL_W-1:0]    w_seed;
  logic [SEL_W-1:0]    w_nxt_a;
  logic                w_found_a;
  logic                w_wraps_a;
  logic [SEL_W-1:0]    w_nxt_b;
  logic                w_found_b;
  logic                w_wraps_b;
  logic                w_cur_ok;
  logic [SEL_W-1:0]    w_eff;
  logic                w_eff_wrap;
  logic [DWELL_W-1:0]  w_eff_cnt;
  logic [DWELL_W-1:0]  w_eff_dwell;
  logic                w_last;

  // Unflatten the channel bus.
  for (genvar k = 0; k < N_CH; k++) begin : g_slice
    assign w_ch[k] = din[k*WIDTH +: WIDTH];
  end

  // State register: tracks the mode seen on the previous edge.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= MODE_DIRECT;
    else        r_state <= w_state_nxt;
  end

  // Next state simply follows the mode input.
  always_comb begin
    w_mode      = mode_e'(mode);
    w_state_nxt = w_mode;
  end

  // On scan entry the search is seeded with the top index so it returns the
  // lowest enabled channel; while scanning it finds the successor of cur.
  always_comb begin
    w_seed = (r_state == MODE_DIRECT) ? c_last : r_cur;
  end

  ch_next_enabled #(.N_CH(N_CH), .SEL_W(SEL_W)) u_find_a (
    .ch_en (ch_en),
    .cur   (w_seed),
    .nxt   (w_nxt_a),
    .found (w_found_a),
    .wraps (w_wraps_a)
  );

  // Effective channel for this edge: a disabled cur is skipped immediately
  // and the skipped-to channel starts a fresh dwell.
  always_comb begin
    w_sel_ok    = ({1'b0, sel} < c_n_ch) && ch_en[sel];
    w_cur_ok    = ch_en[r_cur];
    w_eff       = w_cur_ok ? r_cur     : w_nxt_a;
    w_eff_wrap  = w_cur_ok ? r_pend    : w_wraps_a;
    w_eff_cnt   = w_cur_ok ? r_cnt     : '0;
    w_eff_dwell = w_cur_ok ? r_dwell_l : dwell;
    w_last      = (w_eff_cnt == w_eff_dwell);
  end

  ch_next_enabled #(.N_CH(N_CH), .SEL_W(SEL_W)) u_find_b (
    .ch_en (ch_en),
    .cur   (w_eff),
    .nxt   (w_nxt_b),
    .found (w_found_b),
    .wraps (w_wraps_b)
  );

  // Datapath: output registers, scan pointer, dwell counter, wrap pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cur     <= '0;
      r_cnt     <= '0;
      r_dwell_l <= '0;
      r_pend    <= 1'b0;
      r_y       <= '0;
      r_y_ch    <= '0;
      r_valid   <= 1'b0;
      r_wrap    <= 1'b0;
    end else if (w_mode == MODE_DIRECT) begin
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_wrap  <= 1'b0;
      r_valid <= w_sel_ok;
      if (w_sel_ok) begin
        r_y    <= w_ch[sel];
        r_y_ch <= sel;
      end
    end else if (r_state == MODE_DIRECT) begin
      // Scan entry: position on the lowest enabled channel, no output yet.
      if (w_found_a) r_cur <= w_nxt_a;
      r_cnt     <= '0;
      r_dwell_l <= dwell;
      r_pend    <= 1'b0;
      r_valid   <= 1'b0;
      r_wrap    <= 1'b0;
    end else if (!w_found_a) begin
      // Nothing enabled: freeze the scan and emit nothing.
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_y     <= w_ch[w_eff];
      r_y_ch  <= w_eff;
      r_valid <= 1'b1;
      r_wrap  <= w_eff_wrap;
      if (w_last && w_found_b) begin
        r_cur     <= w_nxt_b;
        r_cnt     <= '0;
        r_dwell_l <= dwell;
        r_pend    <= w_wraps_b;
      end else begin
        r_cur     <= w_eff;
        r_cnt     <= w_eff_cnt + DWELL_W'(1);
        r_dwell_l <= w_eff_dwell;
        r_pend    <= 1'b0;
      end
    end
  end

  assign y       = r_y;
  assign y_ch    = r_y_ch;
  assign y_valid = r_valid;
  assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_mux_nto1_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_nto1_scan
// Purpose  : Directed self-checking bench for mux_nto1_scan (4 x 8 bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_nto1_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  ch_en;
  logic [7:0]  dwell;
  logic [7:0]  y;
  logic [1:0]  y_ch;
  logic        y_valid;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_data [4];

  mux_nto1_scan #(.N_CH(4), .WIDTH(8), .DWELL_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .mode    (mode),
    .sel     (sel),
    .ch_en   (ch_en),
    .dwell   (dwell),
    .y       (y),
    .y_ch    (y_ch),
    .y_valid (y_valid),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] ch, input logic v, input logic w);
    check({tag, ".y"},       {24'd0, y},        {24'd0, exp_data[ch]});
    check({tag, ".y_ch"},    {30'd0, y_ch},     {30'd0, ch});
    check({tag, ".y_valid"}, {31'd0, y_valid},  {31'd0, v});
    check({tag, ".wrap"},    {31'd0, wrap},     {31'd0, w});
  endtask

  initial begin
    bit got;
    exp_data[0] = 8'hA0;
    exp_data[1] = 8'hB1;
    exp_data[2] = 8'hC2;
    exp_data[3] = 8'hD3;

    // Reset with random data for three cycles.
    rst_n = 1'b0; mode = 1'b0; sel = 2'd0; ch_en = 4'hF; dwell = 8'd0;
    for (int i = 0; i < 3; i++) begin
      din = $urandom;
      tick();
    end
    check("rst.y",       {24'd0, y},       32'd0);
    check("rst.y_ch",    {30'd0, y_ch},    32'd0);
    check("rst.y_valid", {31'd0, y_valid}, 32'd0);
    check("rst.wrap",    {31'd0, wrap},    32'd0);

    // DIRECT selection of each channel.
    rst_n = 1'b1;
    din   = 32'hD3C2B1A0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      tick();
      check_out($sformatf("direct%0d", s), 2'(s), 1'b1, 1'b0);
    end

    // DIRECT with the selected channel disabled: outputs hold.
    ch_en = 4'b1011;
    sel = 2'd1;
    tick();
    check_out("direct_b1", 2'd1, 1'b1, 1'b0);
    sel = 2'd2;
    tick();
    check_out("direct_dis", 2'd1, 1'b0, 1'b0);

    // SCAN all channels, dwell=2: three cycles per channel, wrap on return to 0.
    ch_en = 4'hF; dwell = 8'd2; mode = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      check_out($sformatf("scanF[%0d]", i), 2'((i / 3) % 4), 1'b1, (i == 12));
    end

    // SCAN channels 1 and 3 with dwell=0.
    mode = 1'b0;
    tick();
    ch_en = 4'b1010; dwell = 8'd0; mode = 1'b1;
    tick();
    tick();
    check_out("scanA[0]", 2'd1, 1'b1, wrap);  // entry word: only channel checked
    for (int i = 1; i < 8; i++) begin
      tick();
      check_out($sformatf("scanA[%0d]", i), (i % 2 == 0) ? 2'd1 : 2'd3, 1'b1, (i % 2 == 0));
    end

    // Disable the active channel mid-dwell, then shrink dwell mid-channel.
    mode = 1'b0;
    tick();
    ch_en = 4'hF; dwell = 8'd5; mode = 1'b1;
    tick();
    tick();
    check_out("mid.c0a", 2'd0, 1'b1, wrap);
    tick();
    check_out("mid.c0b", 2'd0, 1'b1, 1'b0);
    ch_en = 4'b1110;
    tick();
    check_out("mid.jump", 2'd1, 1'b1, 1'b0);
    dwell = 8'd0;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (j < 5)       check_out($sformatf("mid.d[%0d]", j), 2'd1, 1'b1, 1'b0);
      else if (j == 5) check_out("mid.d[5]", 2'd2, 1'b1, 1'b0);
      else if (j == 6) check_out("mid.d[6]", 2'd3, 1'b1, 1'b0);
      else             check_out("mid.d[7]", 2'd1, 1'b1, 1'b1);
    end

    // No channel enabled: nothing valid, no wrap.
    ch_en = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("none[%0d].y_valid", i), {31'd0, y_valid}, 32'd0);
      check($sformatf("none[%0d].wrap", i),    {31'd0, wrap},    32'd0);
    end

    // Re-enable channel 2 only: must appear within two cycles.
    ch_en = 4'b0100;
    got = 1'b0;
    for (int i = 0; i < 2 && !got; i++) begin
      tick();
      if (y_valid === 1'b1 && y_ch === 2'd2) got = 1'b1;
    end
    check("resume.seen", {31'd0, got}, 32'd1);
    check("resume.y",    {24'd0, y},   {24'd0, exp_data[2]});

    // Reset in the middle of a scan.
    rst_n = 1'b0;
    tick();
    check("rst2.y",       {24'd0, y},       32'd0);
    check("rst2.y_ch",    {30'd0, y_ch},    32'd0);
    check("rst2.y_valid", {31'd0, y_valid}, 32'd0);
    check("rst2.wrap",    {31'd0, wrap},    32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_nto1_scan.md
# mux_nto1_scan

Parametrised, registered N-channel multiplexer. It generalises the team's fixed 4:1 single-bit mux to `N_CH` inputs of `WIDTH` bits each, with a per-channel enable mask. It adds an auto-scan mode that steps through the enabled channels with a programmable dwell time. It sits between sensor/data front-ends and a single shared downstream consumer, and tags every output word with its source channel.

## Interface
Parameters:
- `N_CH`, default 4: number of input channels, ≥2.
- `WIDTH`, default 8: bits per channel.
- `DWELL_W`, default 8: width of the dwell-count input.
- `SEL_W`, derived localparam `$clog2(N_CH)`: not overridable.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: synchronous active-low reset, sampled on `clk`.
- `din`  in  N_CH*WIDTH: flattened inputs; channel k occupies `din[k*WIDTH +: WIDTH]`.
- `mode`  in  1: 0 = DIRECT (select by `sel`), 1 = SCAN (auto-step).
- `sel`  in  SEL_W: channel select, used only in DIRECT.
- `ch_en`  in  N_CH: channel enable mask.
- `dwell`  in  DWELL_W: cycles per channel in SCAN, minus one (0 → 1 cycle).
- `y`  out  WIDTH: registered selected data.
- `y_ch`  out  SEL_W: channel index that produced `y`.
- `y_valid`  out  1: `y`/`y_ch` are valid this cycle.
- `wrap`  out  1: one-cycle pulse when SCAN wraps from the highest enabled channel back to the lowest.

## Operation
- Reset (`rst_n`=0 at a `clk` edge) sets all outputs and internal state to 0: `y`, `y_ch`, `y_valid`, `wrap`, `cur`, `cnt`. The state becomes DIRECT.
- Reset applied mid-scan aborts the scan with no residual output. The state after reset depends only on `mode`.
- States:
  - DIRECT: entered whenever `mode`=0.
  - SCAN: entered whenever `mode`=1.
  - The state follows `mode` each cycle.
- DIRECT:
  - Each cycle, `y` <= `din[sel]` and `y_ch` <= `sel`.
  - `y_valid` <= 1 iff `sel` < `N_CH` and `ch_en[sel]`=1.
  - When `y_valid` would be 0, `y` and `y_ch` hold their previous values.
  - `wrap` stays 0.
- SCAN:
  - Each cycle, `y` <= `din[cur]`, `y_ch` <= `cur`, `y_valid` <= `ch_en[cur]`.
  - `cnt` counts from 0 up to `dwell_l`, where `dwell_l` is `dwell` latched at channel entry.
  - When `cnt`==`dwell_l`, `cur` advances to the next enabled index above `cur`, modulo `N_CH`. `cnt` resets to 0 and `dwell_l` re-latches.
  - If the advance goes to an index ≤ `cur`, `wrap` pulses on the cycle `y_ch` first shows the new channel.
- DIRECT→SCAN transition: `cur` is loaded with the lowest enabled index, `cnt`=0, `dwell` is latched. The first SCAN output appears on the following edge.
- SCAN→DIRECT transition: the counter is cleared; `cur` is retained but unused.
- Boundary conditions:
  - `ch_en` all zero in SCAN: `y_valid`=0, `cur` and `cnt` hold, no `wrap`.
  - Enabling a channel afterwards resumes from `cur` if it is enabled, otherwise from the next enabled index.
  - Current channel disabled mid-dwell: advance on the next edge regardless of `cnt`.
  - Exactly one channel enabled: it is re-selected every `dwell_l`+1 cycles and `wrap` pulses each time.
  - A `dwell` change mid-dwell has no effect until the next channel boundary.

## Timing
- Latency from input to `y`: exactly 1 cycle in both modes. There is no combinational path from inputs to outputs.
- SCAN cadence: each enabled channel is presented for `dwell_l`+1 consecutive cycles. Disabled channels consume zero cycles.
- `wrap` lasts exactly 1 cycle and is aligned with the first valid word of the wrapped-to channel.
- Throughput: one word per cycle. There is no back-pressure; the consumer must sample on `y_valid`.

## Structure
- Package `mux_pkg`:
  - `mode_e` enum: `MODE_DIRECT`=0, `MODE_SCAN`=1.
  - Helper function `clog2_min1`, so that `SEL_W` ≥ 1.
- Sub-module `ch_next_enabled`: combinational rotate-priority finder.
  - Inputs: `ch_en` and `cur`.
  - Outputs: next enabled index, `found`, `wraps`.
  - It is used both for the advance and for the lowest-enabled search (seeded with `cur`=`N_CH`-1).
- The top level holds the state register, `cnt`/`dwell_l`, `cur`, and the output registers.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with random `din` → `y`=0, `y_ch`=0, `y_valid`=0, `wrap`=0. Repeat with reset asserted mid-scan → the same values on the next edge.
- DIRECT, `N_CH`=4, `WIDTH`=8, `din`={8'hD3,8'hC2,8'hB1,8'hA0}, `ch_en`=4'hF, `sel`=0,1,2,3 → `y`=A0,B1,C2,D3, each one cycle after its `sel`. With `ch_en[2]`=0 and `sel`=2 → `y_valid`=0 and `y` holds B1.
- SCAN, `ch_en`=4'hF, `dwell`=2 → `y_ch` sequence 0,0,0,1,1,1,2,2,2,3,3,3,0… with `wrap`=1 only on the first cycle of each return to 0.
- SCAN, `ch_en`=4'b1010, `dwell`=0 → `y_ch` alternates 1,3,1,3. `wrap` pulses on every 1. Channels 0 and 2 never appear.
- Clearing the active channel's enable mid-dwell (`dwell`=5, cnt=2) → the next edge shows the next enabled channel. Changing `dwell` to 0 mid-channel → the current channel still lasts 6 cycles and later channels last 1 cycle.
- `ch_en`=0 in SCAN for 10 cycles → `y_valid`=0 and no `wrap`. Then `ch_en`=4'b0100 → `y_ch`=2 with `y_valid`=1 within 2 cycles.
